pc_update_unit: RTL and testbench

//  Program-counter stage of the single-cycle CPU. Holds the PC register and builds
//  the two candidate next-PC values (PC+4, branch/jump target) plus the select for
//  the downstream 32-bit next-PC mux. Loads the mux output back as the new PC.

---
 rtl/pc_update_unit.sv | 123 ++++++++++++
 tb/tb_pc_update_unit.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/pc_update_unit.sv
// PC stage: PC register, PC+4 / target / redirect select for the
// next-PC mux, BUSYWAIT stall FSM, retire and stall counters.
//
// Ports:
//   CLK, RESET (sync, active-high)
//   BUSYWAIT         memory not ready, freeze PC
//   JUMP, BRANCH,
//   BRANCH_NE, ZERO  redirect controls
//   OFFSET           signed word offset
//   PC_IN            next-PC mux output
//   PC               current PC
//   PC_PLUS4         PC + 4
//   TARGET           PC + 4 + (OFFSET << 2)
//   TAKEN            redirect select
//   INSTR_VALID      PC is fetchable this cycle
//   INSTR_COUNT      retired instructions (wraps)
//   STALL_COUNT      stall cycles (saturates)
module pc_update_unit #(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int          OFFSET_WIDTH = 8,
  parameter int          STALL_CW     = 16
) (
  input  logic                    CLK,
  input  logic                    RESET,
  input  logic                    BUSYWAIT,
  input  logic                    JUMP,
  input  logic                    BRANCH,
  input  logic                    BRANCH_NE,
  input  logic                    ZERO,
  input  logic [OFFSET_WIDTH-1:0] OFFSET,
  input  logic [31:0]             PC_IN,
  output logic [31:0]             PC,
  output logic [31:0]             PC_PLUS4,
  output logic [31:0]             TARGET,
  output logic                    TAKEN,
  output logic                    INSTR_VALID,
  output logic [31:0]             INSTR_COUNT,
  output logic [STALL_CW-1:0]     STALL_COUNT
);

  typedef enum logic [1:0] {
    S_BOOT  = 2'd0,
    S_RUN   = 2'd1,
    S_STALL = 2'd2
  } state_t;

  localparam logic [STALL_CW-1:0] STALL_MAX =
    {STALL_CW{1'b1}};

  state_t              state_q;
  state_t              state_d;
  logic [31:0]         pc_q;
  logic [31:0]         pc_d;
  logic [31:0]         icnt_q;
  logic [STALL_CW-1:0] scnt_q;
  logic                adv;
  logic                stall;
  logic [31:0]         off_ext;
  logic [31:0]         off_bytes;

  // Offset counts instruction words; widen
  // with sign, then scale to bytes.
  assign off_ext = {
    {(32-OFFSET_WIDTH){OFFSET[OFFSET_WIDTH-1]}},
    OFFSET
  };
  assign off_bytes = off_ext << 2;

  assign PC_PLUS4 = pc_q + 32'd4;
  assign TARGET   = PC_PLUS4 + off_bytes;
  assign TAKEN    = JUMP
                  | (BRANCH & ZERO)
                  | (BRANCH_NE & ~ZERO);

  assign PC          = pc_q;
  assign INSTR_VALID = (state_q != S_BOOT);
  assign INSTR_COUNT = icnt_q;
  assign STALL_COUNT = scnt_q;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    adv     = 1'b0;
    stall   = 1'b0;
    unique case (state_q)
      S_BOOT: begin
        state_d = S_RUN;
      end
      S_RUN, S_STALL: begin
        if (BUSYWAIT) begin
          stall   = 1'b1;
          state_d = S_STALL;
        end else begin
          adv     = 1'b1;
          pc_d    = PC_IN;
          state_d = S_RUN;
        end
      end
      default: begin
        state_d = S_BOOT;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= S_BOOT;
      pc_q    <= RESET_PC;
      icnt_q  <= '0;
      scnt_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      if (adv) begin
        icnt_q <= icnt_q + 32'd1;
      end
      if (stall && (scnt_q != STALL_MAX)) begin
        scnt_q <= scnt_q + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pc_update_unit.sv
// Bench for pc_update_unit: directed steps plus
// random traffic against a behavioural model.
module tb_pc_update_unit;

  logic        clk;
  logic        rst;
  logic        bw;
  logic        jmp;
  logic        br;
  logic        bne;
  logic        zf;
  logic [7:0]  off;
  logic [31:0] pcin;
  logic [31:0] pc;
  logic [31:0] pcp4;
  logic [31:0] tgt;
  logic        tkn;
  logic        ivld;
  logic [31:0] icnt;
  logic [15:0] scnt;

  int total = 0;
  int bad   = 0;

  // reference state
  logic [31:0] m_pc;
  logic [31:0] m_ic;
  int          m_sc;
  bit          m_booted;

  pc_update_unit dut (
    .CLK        (clk),
    .RESET      (rst),
    .BUSYWAIT   (bw),
    .JUMP       (jmp),
    .BRANCH     (br),
    .BRANCH_NE  (bne),
    .ZERO       (zf),
    .OFFSET     (off),
    .PC_IN      (pcin),
    .PC         (pc),
    .PC_PLUS4   (pcp4),
    .TARGET     (tgt),
    .TAKEN      (tkn),
    .INSTR_VALID(ivld),
    .INSTR_COUNT(icnt),
    .STALL_COUNT(scnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%h exp=%h",
             tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] m_target();
    int o;
    o = (off >= 8'd128) ? int'(off) - 256
                        : int'(off);
    return m_pc + 32'd4 + 32'(o * 4);
  endfunction

  function automatic logic m_taken();
    return jmp || (br && zf) || (bne && !zf);
  endfunction

  task automatic set(input logic r, input logic b,
                     input logic j, input logic brn,
                     input logic ne, input logic z,
                     input logic [7:0] o,
                     input logic [31:0] pi);
    rst = r; bw = b; jmp = j; br = brn;
    bne = ne; zf = z; off = o; pcin = pi;
  endtask

  task automatic peek();
    #1;
    chk("pc", pc, m_pc);
    chk("pc_plus4", pcp4, m_pc + 32'd4);
    chk("target", tgt, m_target());
    chk("taken", 32'(tkn), 32'(m_taken()));
    chk("instr_valid", 32'(ivld),
        32'(m_booted));
    chk("instr_count", icnt, m_ic);
    chk("stall_count", 32'(scnt), 32'(m_sc));
  endtask

  // apply current inputs across one rising edge
  task automatic tick();
    peek();
    @(posedge clk);
    if (rst) begin
      m_pc = 32'h0; m_ic = 0;
      m_sc = 0; m_booted = 0;
    end else if (!m_booted) begin
      m_booted = 1;
    end else if (bw) begin
      if (m_sc < 65535) m_sc++;
    end else begin
      m_pc = pcin;
      m_ic = m_ic + 1;
    end
    #1;
  endtask

  task automatic adv_to(input logic [31:0] v);
    set(0, 0, 0, 0, 0, 0, 8'h00, v);
    tick();
  endtask

  logic [31:0] ic0;
  int          sc0;
  int          lim;

  initial begin
    m_pc = 0; m_ic = 0; m_sc = 0; m_booted = 0;
    set(1, 0, 0, 0, 0, 0, 8'h00, 32'h0);
    @(posedge clk); #1;
    tick();
    tick();
    chk("rst_pc", pc, 32'h0);
    chk("rst_valid", 32'(ivld), 32'h0);
    chk("rst_pcp4", pcp4, 32'h4);

    // boot then sequential fetch
    for (int i = 0; i < 4; i++) begin
      adv_to(m_pc + 32'd4);
      if (i == 0) chk("boot_pc", pc, 32'h0);
    end
    chk("t1_pc", pc, 32'd12);
    chk("t1_ic", icnt, 32'd3);

    // beq / bne
    adv_to(32'h10);
    set(0, 0, 0, 1, 0, 1, 8'hFE, 32'h0);
    peek();
    chk("t2_tgt", tgt, 32'h0C);
    chk("t2_tkn", 32'(tkn), 32'h1);
    zf = 0;
    peek();
    chk("t2_ntkn", 32'(tkn), 32'h0);
    br = 0; bne = 1;
    peek();
    chk("t2_bne", 32'(tkn), 32'h1);

    // jump
    adv_to(32'h20);
    set(0, 0, 1, 0, 0, 0, 8'h7F, 32'h0);
    pcin = m_target();
    tick();
    chk("t3_pc", pc, 32'h220);

    // stall
    adv_to(32'h40);
    ic0 = m_ic; sc0 = m_sc;
    for (int i = 0; i < 5; i++) begin
      set(0, 1, 0, 0, 0, 0, 8'h00, $urandom);
      tick();
    end
    chk("t4_pc", pc, 32'h40);
    chk("t4_sc", 32'(scnt), 32'(sc0 + 5));
    chk("t4_ic", icnt, ic0);
    adv_to(32'h1234);
    chk("t4_rel", pc, 32'h1234);

    // PC wrap
    adv_to(32'hFFFF_FFFC);
    peek();
    chk("t5_pcp4", pcp4, 32'h0);
    adv_to(pcp4);
    chk("t5_pc", pc, 32'h0);

    // random traffic
    for (int i = 0; i < 300; i++) begin
      set(($urandom_range(0, 49) == 0),
          ($urandom_range(0, 9) < 3),
          1'($urandom), 1'($urandom),
          1'($urandom), 1'($urandom),
          8'($urandom), $urandom);
      if (($urandom & 1) == 1) pcin = m_target();
      tick();
    end

    // reset in the middle of a stall
    adv_to(32'h80);
    adv_to(32'h84);
    set(0, 1, 0, 0, 0, 0, 8'h00, 32'h0);
    tick();
    tick();
    set(1, 1, 0, 0, 0, 0, 8'h00, 32'h0);
    tick();
    chk("t6_pc", pc, 32'h0);
    chk("t6_ic", icnt, 32'h0);
    chk("t6_sc", 32'(scnt), 32'h0);
    chk("t6_valid", 32'(ivld), 32'h0);

    // stall counter saturation
    set(0, 1, 0, 0, 0, 0, 8'h00, 32'h0);
    tick();
    lim = 0;
    while (m_sc < 65535 && lim < 70000) begin
      pcin = $urandom;
      tick();
      lim++;
    end
    chk("sat_bound", 32'(m_sc), 32'd65535);
    for (int i = 0; i < 3; i++) tick();
    chk("sat_sc", 32'(scnt), 32'hFFFF);
    chk("sat_pc", pc, 32'h0);
    adv_to(32'h8);
    chk("sat_rel", pc, 32'h8);

    $display("test done: total=%0d bad=%0d",
             total, bad);
    $finish;
  end

endmodule
